// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_RUN   = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: assembles an MSB-first byte stream into 32-bit words, writes them
// to instruction memory from address 0, and holds the CPU in reset until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic [7:0]        csum
);

    localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]      LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_e              state_q,    state_d;
    logic [ADDR_W:0]     len_q,      len_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [WORD_W-1:0]   wdata_q,    wdata_d;
    logic [7:0]          csum_q,     csum_d;

    logic [ADDR_W:0]     len_sat;
    logic [ADDR_W:0]     word_cnt_inc;

    assign len_sat      = (len > MAX_LEN) ? MAX_LEN : len;
    assign word_cnt_inc = word_cnt_q + 1'b1;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        csum_d     = csum_q;

        unique case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    len_d      = len_sat;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    addr_d     = '0;
                    csum_d     = '0;
                    state_d    = (len_sat == '0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    wdata_d    = {wdata_q[WORD_W-9:0], byte_data};
                    csum_d     = csum_q ^ byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // Address wraps to 0 after the last word of a full-capacity load.
                word_cnt_d = word_cnt_inc;
                addr_d     = addr_q + 1'b1;
                state_d    = (word_cnt_inc == len_q) ? S_RUN : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            csum_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            csum_q     <= csum_d;
        end
    end

    // Control outputs decode the flopped state only, so they never glitch on inputs.
    assign byte_ready = (state_q == S_LOAD);
    assign imem_we    = (state_q == S_WRITE);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign cpu_rst    = (state_q == S_RUN);
    assign done       = (state_q == S_RUN);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign csum       = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads compared against
// a word/checksum model built directly from the byte stream.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic [7:0]        csum;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] stream[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .csum       (csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side observer: records every write strobe with its address and data.
    always @(negedge clk) begin
        if (imem_we) wr_q.push_back('{int'(imem_addr), imem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rst"},    cpu_rst,    0);
        check({tag, "_done"},       done,       0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_byte_ready"}, byte_ready, 0);
        check({tag, "_imem_we"},    imem_we,    0);
        check({tag, "_csum"},       csum,       0);
        check({tag, "_addr"},       imem_addr,  0);
        check({tag, "_wdata"},      imem_wdata, 0);
    endtask

    task automatic fill_random(input int n_words);
        stream.delete();
        for (int i = 0; i < 4 * n_words; i++) stream.push_back(8'($urandom));
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random valid.
    task automatic run_load(input string tag, input int len_in, input int mode, input bit from_run);
        int          n;
        int          idx;
        int          cycles;
        int          bound;
        bit          v;
        logic [7:0]  exp_csum;
        logic [31:0] exp_word;

        n = (len_in > DEPTH) ? DEPTH : len_in;
        bound = 20 * n + 50;
        exp_csum = 8'h00;
        foreach (stream[i]) exp_csum ^= stream[i];

        @(negedge clk);
        start = 1'b1;
        len   = (ADDR_W+1)'(len_in);
        wr_q.delete();
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        if (from_run) check({tag, "_rehold_cpu"}, cpu_rst, 0);
        check({tag, "_busy_entry"}, busy, 1);

        idx = 0;
        cycles = 0;
        while (cycles < bound) begin
            if (cpu_rst) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2) == 0;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            v = v && (idx < stream.size());
            byte_valid = v;
            byte_data  = v ? stream[idx] : 8'($urandom);
            if (v && byte_ready) idx++;
            @(negedge clk);
            cycles++;
        end
        byte_valid = 1'b0;

        check({tag, "_timeout"}, cycles < bound, 1);
        if (mode == 0) check({tag, "_latency"}, cycles, 5 * n);
        else if (mode == 1) check({tag, "_stall_later"}, cycles > 5 * n, 1);
        else check({tag, "_min_latency"}, cycles >= 5 * n, 1);
        check({tag, "_bytes_used"}, idx, 4 * n);
        check({tag, "_n_writes"}, wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            exp_word = {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
            check({tag, "_waddr"}, wr_q[i].addr, i % DEPTH);
            check({tag, "_wdata"}, wr_q[i].data, exp_word);
        end
        check({tag, "_csum"}, csum, exp_csum);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
    endtask

    initial begin
        int idx;
        int cycles;

        rst        = 1'b0;
        start      = 1'b0;
        len        = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        apply_reset();

        stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h85, 8'h40, 8'h20};
        run_load("basic", 2, 0, 1'b0);

        run_load("stall", 2, 1, 1'b1);

        stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load("reload", 1, 0, 1'b1);

        // Zero-length load from IDLE releases the CPU on the next cycle.
        apply_reset();
        @(negedge clk);
        start = 1'b1;
        len   = '0;
        wr_q.delete();
        @(negedge clk);
        start = 1'b0;
        check("zero_cpu_rst", cpu_rst, 1);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("zero_no_write", wr_q.size(), 0);

        // Reset after six bytes of a two-word load.
        fill_random(2);
        @(negedge clk);
        start = 1'b1;
        len   = (ADDR_W+1)'(2);
        wr_q.delete();
        @(negedge clk);
        start  = 1'b0;
        idx    = 0;
        cycles = 0;
        while (idx < 6 && cycles < 40) begin
            byte_valid = 1'b1;
            byte_data  = stream[idx];
            if (byte_ready) idx++;
            @(negedge clk);
            cycles++;
        end
        byte_valid = 1'b0;
        check("midrst_feed_timeout", idx, 6);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst_async");
        repeat (2) @(negedge clk);
        check("midrst_one_write", wr_q.size(), 1);
        rst = 1'b1;

        for (int k = 0; k < 6; k++) begin
            int n_w;
            n_w = $urandom_range(1, 6);
            fill_random(n_w);
            run_load("rand", n_w, k % 3, k != 0);
        end

        // Oversized length saturates to full capacity.
        fill_random(DEPTH);
        run_load("sat", DEPTH + 3, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
